// File: rtl/ppu_ctrl_csr.sv
// rtl/ppu_ctrl_csr.sv - PPU frame-level control register file with atomic commit
// Purpose: Avalon-MM slave holding staging copies of the PPU scroll, enable and
//   background-colour controls. A CTRL commit publishes them onto ppu_* together.
//   Also provides commit-pending status, a frame counter and a frame interrupt.
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   sync                 one-cycle frame-boundary pulse
//   avs_address/write/writedata/read/readdata   register bus, read latency 1
//   ppu_bgscroll/fgscroll/enable/bgcolor        published control values
//   irq                  frame interrupt, level
module ppu_ctrl_csr #(
  parameter logic [2:0]  ENABLE_RST  = 3'b111,
  parameter logic [23:0] BGCOLOR_RST = 24'h000000,
  parameter int          FCNT_W      = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sync,
  input  logic [2:0]  avs_address,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  input  logic        avs_read,
  output logic [31:0] avs_readdata,
  output logic [31:0] ppu_bgscroll,
  output logic [31:0] ppu_fgscroll,
  output logic [2:0]  ppu_enable,
  output logic [23:0] ppu_bgcolor,
  output logic        irq
);

  localparam logic [2:0] A_BGSCROLL = 3'd0, A_FGSCROLL = 3'd1, A_ENABLE = 3'd2,
                         A_BGCOLOR  = 3'd3, A_CTRL     = 3'd4, A_FCOUNT = 3'd5,
                         A_IRQSTAT  = 3'd6, A_IRQEN    = 3'd7;

  logic [31:0]       stg_bgscroll_q, stg_bgscroll_d;
  logic [31:0]       stg_fgscroll_q, stg_fgscroll_d;
  logic [2:0]        stg_enable_q,   stg_enable_d;
  logic [23:0]       stg_bgcolor_q,  stg_bgcolor_d;
  logic [31:0]       pub_bgscroll_q, pub_bgscroll_d;
  logic [31:0]       pub_fgscroll_q, pub_fgscroll_d;
  logic [2:0]        pub_enable_q,   pub_enable_d;
  logic [23:0]       pub_bgcolor_q,  pub_bgcolor_d;
  logic              pending_q,      pending_d;
  logic [FCNT_W-1:0] fcount_q,       fcount_d;
  logic              irqstat_q,      irqstat_d;
  logic              irqen_q,        irqen_d;
  logic [31:0]       readdata_q,     readdata_d;

  logic        commit;
  logic [31:0] rd_mux;
  logic [31:0] fcount_ext;

  assign commit     = avs_write && (avs_address == A_CTRL) && avs_writedata[0];
  assign fcount_ext = 32'(fcount_q);

  // Read mux sees only registered state, so a simultaneous write returns the old value.
  always_comb begin
    rd_mux = 32'd0;
    case (avs_address)
      A_BGSCROLL: rd_mux = stg_bgscroll_q;
      A_FGSCROLL: rd_mux = stg_fgscroll_q;
      A_ENABLE:   rd_mux = {29'd0, stg_enable_q};
      A_BGCOLOR:  rd_mux = {8'd0, stg_bgcolor_q};
      A_CTRL:     rd_mux = {31'd0, pending_q};
      A_FCOUNT:   rd_mux = fcount_ext;
      A_IRQSTAT:  rd_mux = {31'd0, irqstat_q};
      A_IRQEN:    rd_mux = {31'd0, irqen_q};
      default:    rd_mux = 32'd0;
    endcase
  end

  always_comb begin
    stg_bgscroll_d = stg_bgscroll_q;
    stg_fgscroll_d = stg_fgscroll_q;
    stg_enable_d   = stg_enable_q;
    stg_bgcolor_d  = stg_bgcolor_q;
    irqen_d        = irqen_q;
    if (avs_write) begin
      case (avs_address)
        A_BGSCROLL: stg_bgscroll_d = avs_writedata;
        A_FGSCROLL: stg_fgscroll_d = avs_writedata;
        A_ENABLE:   stg_enable_d   = avs_writedata[2:0];
        A_BGCOLOR:  stg_bgcolor_d  = avs_writedata[23:0];
        A_IRQEN:    irqen_d        = avs_writedata[0];
        default:    ;
      endcase
    end

    // Commit copies the pre-edge staging values; a same-cycle staging write
    // targets another address, so there is nothing to forward.
    pub_bgscroll_d = commit ? stg_bgscroll_q : pub_bgscroll_q;
    pub_fgscroll_d = commit ? stg_fgscroll_q : pub_fgscroll_q;
    pub_enable_d   = commit ? stg_enable_q   : pub_enable_q;
    pub_bgcolor_d  = commit ? stg_bgcolor_q  : pub_bgcolor_q;

    // A commit coinciding with sync was missed downstream, so pending survives.
    if (commit)    pending_d = 1'b1;
    else if (sync) pending_d = 1'b0;
    else           pending_d = pending_q;

    fcount_d = sync ? fcount_q + FCNT_W'(1) : fcount_q;

    // Set has priority over write-1-to-clear.
    if (sync)
      irqstat_d = 1'b1;
    else if (avs_write && (avs_address == A_IRQSTAT) && avs_writedata[0])
      irqstat_d = 1'b0;
    else
      irqstat_d = irqstat_q;

    readdata_d = avs_read ? rd_mux : readdata_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stg_bgscroll_q <= 32'd0;
      stg_fgscroll_q <= 32'd0;
      stg_enable_q   <= ENABLE_RST;
      stg_bgcolor_q  <= BGCOLOR_RST;
      pub_bgscroll_q <= 32'd0;
      pub_fgscroll_q <= 32'd0;
      pub_enable_q   <= ENABLE_RST;
      pub_bgcolor_q  <= BGCOLOR_RST;
      pending_q      <= 1'b0;
      fcount_q       <= '0;
      irqstat_q      <= 1'b0;
      irqen_q        <= 1'b0;
      readdata_q     <= 32'd0;
    end else begin
      stg_bgscroll_q <= stg_bgscroll_d;
      stg_fgscroll_q <= stg_fgscroll_d;
      stg_enable_q   <= stg_enable_d;
      stg_bgcolor_q  <= stg_bgcolor_d;
      pub_bgscroll_q <= pub_bgscroll_d;
      pub_fgscroll_q <= pub_fgscroll_d;
      pub_enable_q   <= pub_enable_d;
      pub_bgcolor_q  <= pub_bgcolor_d;
      pending_q      <= pending_d;
      fcount_q       <= fcount_d;
      irqstat_q      <= irqstat_d;
      irqen_q        <= irqen_d;
      readdata_q     <= readdata_d;
    end
  end

  assign avs_readdata = readdata_q;
  assign ppu_bgscroll = pub_bgscroll_q;
  assign ppu_fgscroll = pub_fgscroll_q;
  assign ppu_enable   = pub_enable_q;
  assign ppu_bgcolor  = pub_bgcolor_q;
  assign irq          = irqstat_q & irqen_q;

endmodule

// File: tb/tb_ppu_ctrl_csr.sv
// tb/tb_ppu_ctrl_csr.sv - directed self-checking bench for ppu_ctrl_csr
module tb_ppu_ctrl_csr;

  logic        clk;
  logic        rst;
  logic        sync;
  logic [2:0]  avs_address;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic        avs_read;
  logic [31:0] avs_readdata;
  logic [31:0] ppu_bgscroll;
  logic [31:0] ppu_fgscroll;
  logic [2:0]  ppu_enable;
  logic [23:0] ppu_bgcolor;
  logic        irq;

  int n_checks;
  int n_fails;
  logic [31:0] exp_fc;
  logic [31:0] rst_vals [8];

  ppu_ctrl_csr dut (
    .clk           (clk),
    .rst           (rst),
    .sync          (sync),
    .avs_address   (avs_address),
    .avs_write     (avs_write),
    .avs_writedata (avs_writedata),
    .avs_read      (avs_read),
    .avs_readdata  (avs_readdata),
    .ppu_bgscroll  (ppu_bgscroll),
    .ppu_fgscroll  (ppu_fgscroll),
    .ppu_enable    (ppu_enable),
    .ppu_bgcolor   (ppu_bgcolor),
    .irq           (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One bus cycle, driven between negedges so the DUT samples it on the posedge.
  task automatic bus(input logic w, input logic r, input logic [2:0] a,
                     input logic [31:0] d, input logic s);
    @(negedge clk);
    avs_write = w; avs_read = r; avs_address = a; avs_writedata = d; sync = s;
    @(negedge clk);
    avs_write = 1'b0; avs_read = 1'b0; avs_address = 3'd0; avs_writedata = 32'd0; sync = 1'b0;
    if (s) exp_fc++;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    bus(1'b1, 1'b0, a, d, 1'b0);
  endtask

  task automatic rd(input string tag, input logic [2:0] a, input logic [31:0] exp);
    bus(1'b0, 1'b1, a, 32'd0, 1'b0);
    check(tag, avs_readdata, exp);
  endtask

  task automatic pulse_sync();
    bus(1'b0, 1'b0, 3'd0, 32'd0, 1'b1);
  endtask

  initial begin
    n_checks = 0; n_fails = 0; exp_fc = 32'd0;
    rst = 1'b1; sync = 1'b0; avs_address = 3'd0; avs_write = 1'b0;
    avs_writedata = 32'd0; avs_read = 1'b0;
    rst_vals = '{32'd0, 32'd0, 32'd7, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};

    #12;
    check("rst_enable", {29'd0, ppu_enable}, 32'd7);
    check("rst_irq", {31'd0, irq}, 32'd0);
    check("rst_readdata", avs_readdata, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) rd($sformatf("rst_read_a%0d", i), 3'(i), rst_vals[i]);

    // Staging write then commit
    wr(3'd0, 32'h0001_0020);
    rd("bgscroll_rb", 3'd0, 32'h0001_0020);
    check("bgscroll_unpub", ppu_bgscroll, 32'd0);
    wr(3'd4, 32'd1);
    check("bgscroll_pub", ppu_bgscroll, 32'h0001_0020);
    rd("pending_set", 3'd4, 32'd1);
    pulse_sync();
    rd("pending_clr", 3'd4, 32'd0);

    // CTRL write with bit0=0 is a no-op
    wr(3'd1, 32'h0000_0066);
    wr(3'd4, 32'hFFFF_FFFE);
    check("ctrl0_nocommit", ppu_fgscroll, 32'd0);
    rd("ctrl0_nopending", 3'd4, 32'd0);

    // Commit coinciding with sync
    wr(3'd1, 32'h0000_0055);
    bus(1'b1, 1'b0, 3'd4, 32'd1, 1'b1);
    check("sync_commit_pub", ppu_fgscroll, 32'h55);
    rd("sync_commit_pend", 3'd4, 32'd1);
    pulse_sync();
    rd("sync_commit_clr", 3'd4, 32'd0);

    // Back-to-back commits: last wins
    wr(3'd3, 32'h00AB_CDEF);
    wr(3'd4, 32'd1);
    check("bgcolor_c1", {8'd0, ppu_bgcolor}, 32'h00AB_CDEF);
    wr(3'd3, 32'hFF12_3456);
    wr(3'd4, 32'd1);
    check("bgcolor_c2", {8'd0, ppu_bgcolor}, 32'h0012_3456);
    rd("bgcolor_pend", 3'd4, 32'd1);
    rd("bgcolor_rb_mask", 3'd3, 32'h0012_3456);
    pulse_sync();
    check("sync_holds_bgcolor", {8'd0, ppu_bgcolor}, 32'h0012_3456);

    // Unused bits ignored, read+write returns old value, RO write ignored
    wr(3'd2, 32'hFFFF_FFFA);
    rd("enable_mask", 3'd2, 32'd2);
    check("enable_unpub", {29'd0, ppu_enable}, 32'd7);
    bus(1'b1, 1'b1, 3'd0, 32'hDEAD_BEEF, 1'b0);
    check("rw_old", avs_readdata, 32'h0001_0020);
    rd("rw_new", 3'd0, 32'hDEAD_BEEF);
    @(negedge clk);
    check("readdata_hold", avs_readdata, 32'hDEAD_BEEF);
    wr(3'd5, 32'h1234_5678);
    rd("fcount_ro", 3'd5, exp_fc);

    // Interrupts
    wr(3'd6, 32'd1);
    rd("irqstat_w1c", 3'd6, 32'd0);
    wr(3'd7, 32'd1);
    rd("irqen_rb", 3'd7, 32'd1);
    check("irq_none", {31'd0, irq}, 32'd0);
    pulse_sync();
    check("irq_set", {31'd0, irq}, 32'd1);
    rd("fcount_a", 3'd5, exp_fc);
    bus(1'b1, 1'b0, 3'd6, 32'd1, 1'b1);
    check("irq_set_wins", {31'd0, irq}, 32'd1);
    rd("fcount_b", 3'd5, exp_fc);
    wr(3'd6, 32'd1);
    check("irq_cleared", {31'd0, irq}, 32'd0);

    // Asynchronous reset while pending
    wr(3'd1, 32'h0000_0077);
    wr(3'd4, 32'd1);
    check("pre_rst_fg", ppu_fgscroll, 32'h77);
    wr(3'd1, 32'h0000_0055);
    wr(3'd4, 32'd1);
    rd("pre_rst_pend", 3'd4, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_fg", ppu_fgscroll, 32'd0);
    check("async_rst_bgcolor", {8'd0, ppu_bgcolor}, 32'd0);
    check("async_rst_enable", {29'd0, ppu_enable}, 32'd7);
    check("async_rst_rdata", avs_readdata, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    exp_fc = 32'd0;
    rd("post_rst_pend", 3'd4, 32'd0);
    rd("post_rst_fcount", 3'd5, exp_fc);
    rd("post_rst_irqen", 3'd7, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
